// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and status controller for a FIFO memory of arbitrary depth.
// Drives the memory enables and addresses and the flow-control and sticky error flags.
module fifo_ptr_ctrl #(
  parameter int MEM_SIZE = 4,
  parameter int PTR_L    = 2,
  parameter int AF_TH    = 3,
  parameter int AE_TH    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_wr,
  input  logic             fifo_rd,
  input  logic             err_clr,
  output logic             push,
  output logic             pop,
  output logic [PTR_L-1:0] wr_ptr,
  output logic [PTR_L-1:0] rd_ptr,
  output logic [PTR_L:0]   count,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int CW = PTR_L + 1;
  localparam logic [PTR_L-1:0] LAST_PTR = PTR_L'(MEM_SIZE - 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(MEM_SIZE);

  logic ovf_set;
  logic unf_set;

  // Handshake: fifo_wr/fifo_rd are requests; push/pop are the same-cycle grants.
  // A request is transferred only on a cycle where its grant is high; an
  // ungranted request has no effect other than possibly setting an error flag.
  assign push = !reset && fifo_wr && (!fifo_full || fifo_rd);
  assign pop  = !reset && fifo_rd && !fifo_empty;

  assign ovf_set = fifo_wr && fifo_full && !fifo_rd;
  assign unf_set = fifo_rd && fifo_empty;

  assign fifo_full    = (count == FULL_CNT);
  assign fifo_empty   = (count == '0);
  assign almost_full  = (count >= CW'(AF_TH));
  assign almost_empty = (count <= CW'(AE_TH));

  // Pointers wrap explicitly at MEM_SIZE-1 so non power-of-two depths work.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A fresh error takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (ovf_set)      overflow_err <= 1'b1;
      else if (err_clr) overflow_err <= 1'b0;
      if (unf_set)      underflow_err <= 1'b1;
      else if (err_clr) underflow_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl (depth 5, 3-bit pointers): directed scenarios then random traffic,
// expected post-edge state queued at drive time and compared after the clock edge.
module tb_fifo_ptr_ctrl;

  localparam int MS = 5;
  localparam int PL = 3;
  localparam int AF = 3;
  localparam int AE = 1;
  localparam int W  = 2 * PL + (PL + 1) + 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_wr = 1'b0;
  logic          fifo_rd = 1'b0;
  logic          err_clr = 1'b0;
  logic          push, pop;
  logic [PL-1:0] wr_ptr, rd_ptr;
  logic [PL:0]   count;
  logic          fifo_full, fifo_empty, almost_full, almost_empty;
  logic          overflow_err, underflow_err;

  fifo_ptr_ctrl #(.MEM_SIZE(MS), .PTR_L(PL), .AF_TH(AF), .AE_TH(AE)) dut (
    .clk(clk), .reset(reset), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .err_clr(err_clr),
    .push(push), .pop(pop), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .count(count),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // reference model state
  int m_wr = 0, m_rd = 0, m_cnt = 0;
  bit m_ov = 0, m_un = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_model();
    logic [PL-1:0] w, r;
    logic [PL:0]   c;
    w = PL'(m_wr);
    r = PL'(m_rd);
    c = (PL+1)'(m_cnt);
    return {w, r, c, m_cnt == MS, m_cnt == 0, m_cnt >= AF, m_cnt <= AE, m_ov, m_un};
  endfunction

  task automatic step(input logic wr, input logic rd, input logic clr, input logic rst);
    bit ep, eo, full_pre, empty_pre;
    logic [W-1:0] exp, got;
    @(negedge clk);
    fifo_wr = wr; fifo_rd = rd; err_clr = clr; reset = rst;
    #1;
    full_pre  = (m_cnt == MS);
    empty_pre = (m_cnt == 0);
    ep = !rst && wr && (!full_pre || rd);
    eo = !rst && rd && !empty_pre;
    check_eq("push", push, ep);
    check_eq("pop", pop, eo);
    if (rst) begin
      m_wr = 0; m_rd = 0; m_cnt = 0; m_ov = 0; m_un = 0;
    end else begin
      if (ep) m_wr = (m_wr == MS - 1) ? 0 : m_wr + 1;
      if (eo) m_rd = (m_rd == MS - 1) ? 0 : m_rd + 1;
      m_cnt = m_cnt + int'(ep) - int'(eo);
      if (wr && full_pre && !rd) m_ov = 1; else if (clr) m_ov = 0;
      if (rd && empty_pre)       m_un = 1; else if (clr) m_un = 0;
    end
    exp_q.push_back(pack_model());
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    got = {wr_ptr, rd_ptr, count, fifo_full, fifo_empty, almost_full, almost_empty,
           overflow_err, underflow_err};
    check_eq("wr_ptr", 32'(got[W-1 -: PL]), 32'(exp[W-1 -: PL]));
    check_eq("rd_ptr", 32'(got[W-1-PL -: PL]), 32'(exp[W-1-PL -: PL]));
    check_eq("count", 32'(got[9:6]), 32'(exp[9:6]));
    check_eq("fifo_full", 32'(got[5]), 32'(exp[5]));
    check_eq("fifo_empty", 32'(got[4]), 32'(exp[4]));
    check_eq("almost_full", 32'(got[3]), 32'(exp[3]));
    check_eq("almost_empty", 32'(got[2]), 32'(exp[2]));
    check_eq("overflow_err", 32'(got[1]), 32'(exp[1]));
    check_eq("underflow_err", 32'(got[0]), 32'(exp[0]));
  endtask

  initial begin
    // reset, then reset with count=3
    repeat (2) step(0, 0, 0, 1);
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    // fill to full; wr_ptr wraps on the 5th write
    repeat (5) step(1, 0, 0, 0);
    // overflow attempt, then simultaneous write+read while full
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    // new overflow with err_clr in the same cycle: error wins
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    // drain to empty, then read+write while empty
    repeat (6) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 1, 0);
    // threshold walk 0..MS and back
    step(0, 0, 0, 1);
    repeat (MS) step(1, 0, 0, 0);
    repeat (MS) step(0, 1, 0, 0);
    // sustained write+read at constant occupancy
    repeat (2) step(1, 0, 0, 0);
    repeat (20) step(1, 1, 0, 0);
    // random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
    if (exp_q.size() != 0) check_eq("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
